boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Upstream of the multicycle CPU. Receives a program as a byte stream and writes it
//  as 32-bit words into Memoria. Holds the CPU in reset while loading and releases it
//  only after a good checksum. Top level muxes Memoria address/data/write to the loader
//  while cpu_reset=1.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of the first word written
//  MAX_WORDS  64             largest legal word count (Memoria is 256 bytes)
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  in_valid   in   1   in_data holds a byte
//  in_data    in   8   stream byte
//  in_ready   out  1   byte accepted on a clock edge where in_valid & in_ready
//  mem_addr   out  32  Memoria byte address (word aligned)
//  mem_wdata  out  32  Memoria write data
//  mem_write  out  1   Memoria write enable, one-cycle pulse
//  cpu_reset  out  1   active-high reset to cpu; 1 until a load succeeds
//  done       out  1   load succeeded; CPU running
//  error      out  1   load failed; CPU held in reset
// BEHAVIOUR
//  Frame: CNT_HI, CNT_LO (16-bit word count N, big-endian), 4*N data bytes
//   (big-endian words), then CSUM = XOR of the data bytes only.
//  FSM states: HDR_HI -> HDR_LO -> DATA -> CSUM -> RUN | ERROR.
//   HDR_HI: accept byte into cnt[15:8].
//   HDR_LO: accept byte into cnt[7:0]. The check uses the full count {cnt_hi,byte}:
//    count>MAX_WORDS -> ERROR; count==0 -> CSUM; otherwise -> DATA.
//   DATA: shift each byte into word[31:0] as {word[23:0],byte}; xor it into csum.
//    On the 4th byte, the next cycle drives mem_write=1,
//    mem_addr=BASE_ADDR+4*idx, mem_wdata=assembled word; idx then increments.
//    After the write for idx==N-1 -> CSUM.
//   CSUM: accept one byte. Equal to the running xor -> RUN, otherwise -> ERROR.
//   RUN: cpu_reset=0, done=1. ERROR: cpu_reset=1, error=1. Both are terminal;
//    only reset leaves them.
//  in_ready = (state in HDR_HI/HDR_LO/DATA/CSUM) & ~mem_write & reset. It is
//   combinational from registered state. Bytes are never accepted during a write cycle.
//  in_valid=0 gaps of any length stall with no state change. in_data is ignored
//   unless the handshake completes.
//  Width rules: idx is 16 bits. Address arithmetic is 32-bit modulo; no overflow check.
//  Reset values, asserted asynchronously at any time including mid-load:
//   state=HDR_HI, cnt=0, idx=0, byte count=0, csum=0, word=0;
//   mem_write=0, mem_addr=BASE_ADDR, mem_wdata=0; cpu_reset=1, done=0, error=0.
//  Words already written before a mid-load reset stay in memory. The next frame
//   restarts at BASE_ADDR.
//  Latency: CPU released on the edge after the CSUM byte is accepted.
//   cpu_reset falls and done rises in the same cycle.
// TESTING
//  1 Frame 00 02 12 34 56 78 AA BB CC DD 08 ->
//    writes 0x12345678@0x0 and 0xAABBCCDD@0x4; then done=1, cpu_reset=0.
//  2 Frame 00 00 00 -> no mem_write; done=1 after 3 accepted bytes.
//  3 Frame 00 41 (65 > MAX_WORDS) -> error=1 right after CNT_LO; in_ready=0;
//    no writes; cpu_reset stays 1.
//  4 Test 1 with CSUM=0x09 -> both writes occur; then error=1, done=0, cpu_reset=1.
//  5 Test 1 with random in_valid gaps of 0-5 cycles -> identical writes and result.
//    in_ready=0 in every write cycle.
//  6 reset low for 1 cycle after 6 data bytes; then send test 1 ->
//    outputs at reset values during reset; then a correct load at BASE_ADDR.

Source files
------------

// File: rtl/boot_loader.sv
// Purpose : receives a program as a byte stream, writes it into Memoria as 32-bit
//           words and releases the CPU from reset after a good XOR checksum.
// Latency : a word is written the cycle after its 4th byte is accepted; the CPU is
//           released on the edge that accepts the checksum byte.
// Backpressure: in_ready drops during each write cycle and after RUN/ERROR;
//           in_valid gaps stall the loader with no state change.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   in_valid/in_data  byte stream input; in_ready accepts on valid & ready
//   mem_addr/mem_wdata/mem_write  Memoria write port (one-cycle write pulse)
//   cpu_reset         held high until a load completes with a good checksum
//   done / error      terminal load result flags
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [7:0]  csum;
  logic [31:0] word;

  logic        loading;
  logic        accept;
  logic [15:0] count_full;
  logic        last_write;

  assign loading  = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);
  // Including the reset pin keeps in_ready low the moment reset is asserted,
  // before the asynchronous clear has propagated through the state register.
  assign in_ready = loading & ~mem_write & reset;
  assign accept   = in_valid & in_ready;

  // The range check must see the high byte already captured plus the byte
  // arriving now, since cnt[7:0] is only registered on this same edge.
  assign count_full = {cnt[15:8], in_data};
  assign last_write = (idx == (cnt - 16'd1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_HDR_HI;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and result outputs
  always_comb begin
    state_nxt = state;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_HDR_HI: begin
        if (accept) state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (accept) begin
          if (count_full > MAX_CNT)      state_nxt = S_ERROR;
          else if (count_full == 16'd0)  state_nxt = S_CSUM;
          else                           state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // Leave only once the final word's write pulse has been issued.
        if (mem_write && last_write) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_nxt = (in_data == csum) ? S_RUN : S_ERROR;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_nxt = S_ERROR;
      end
    endcase
  end

  // Datapath: header capture, word assembly, running checksum, write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= 16'd0;
      idx       <= 16'd0;
      bcnt      <= 2'd0;
      csum      <= 8'd0;
      word      <= 32'd0;
      mem_write <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'd0;
    end else begin
      mem_write <= 1'b0;
      if (state == S_HDR_HI && accept) cnt[15:8] <= in_data;
      if (state == S_HDR_LO && accept) cnt[7:0]  <= in_data;
      if (state == S_DATA && accept) begin
        word <= {word[23:0], in_data};
        csum <= csum ^ in_data;
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          mem_write <= 1'b1;
          mem_addr  <= BASE_ADDR + {14'd0, idx, 2'b00};
          mem_wdata <= {word[23:0], in_data};
        end
      end
      // Advance the word index during the write cycle so the next word's
      // address is ready well before its 4th byte can arrive.
      if (mem_write) idx <= idx + 16'd1;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: fixed frame vectors, gap insertion,
// a mid-load reset sequence and randomized frames against a frame-level model.
module tb_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        cpu_reset;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  boot_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          ready_viol = 0;
  int          pulse_viol = 0;
  logic        prev_write = 1'b0;
  bit          e_done;
  bit          e_err;
  int          n_acc;
  bit          send_ok;

  // Write-port monitor: records every write, flags in_ready during a write
  // and any write pulse longer than one cycle.
  always @(negedge clock) begin
    if (mem_write) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      if (in_ready) ready_viol++;
      if (prev_write) pulse_viol++;
    end
    prev_write = mem_write;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Frame-level reference: interprets the byte list directly.
  task automatic model();
    int         n;
    logic [7:0] x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    n = int'({frame[0], frame[1]});
    if (n > 64) begin
      n_acc  = 2;
      e_done = 1'b0;
      e_err  = 1'b1;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        w = {frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]};
        x = x ^ frame[2+4*i] ^ frame[3+4*i] ^ frame[4+4*i] ^ frame[5+4*i];
        exp_addr.push_back(32'(4 * i));
        exp_data.push_back(w);
      end
      n_acc  = 3 + 4 * n;
      e_done = (frame[2+4*n] == x);
      e_err  = !e_done;
    end
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {in_ready, mem_write, cpu_reset, done, error, mem_addr, mem_wdata},
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_reset_vals("reset_vals");
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic send_bytes(input int cnt, input int max_gap);
    int g;
    bit ok;
    send_ok = 1'b1;
    for (int i = 0; i < cnt && send_ok; i++) begin
      g = $urandom_range(max_gap, 0);
      repeat (g) begin
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = frame[i];
        #1;
        if (t == 0 && i == cnt - 1)
          check("held_before_last", {cpu_reset, done, error}, 3'b100);
        if (in_ready) begin
          @(posedge clock);
          ok = 1'b1;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout byte=%0d in_ready=%0b required=1", i, in_ready);
        send_ok = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input string name, input int cnt, input int max_gap);
    int base;
    int rv0;
    int pv0;
    int nexp;
    base = got_addr.size();
    rv0  = ready_viol;
    pv0  = pulse_viol;
    nexp = exp_addr.size();
    send_bytes(cnt, max_gap);
    @(negedge clock);
    in_valid = 1'b0;
    // Result must be visible in the cycle right after the last accepted byte.
    check({name, "_result"}, {done, error, cpu_reset, in_ready},
          {e_done, e_err, !e_done, 1'b0});
    repeat (4) @(negedge clock);
    check({name, "_nwrites"}, got_addr.size() - base, nexp);
    for (int i = 0; i < nexp && base + i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), got_addr[base+i], exp_addr[i]);
      check($sformatf("%s_data%0d", name, i), got_data[base+i], exp_data[i]);
    end
    check({name, "_write_cycle_rules"}, {32'(ready_viol - rv0), 32'(pulse_viol - pv0)}, 64'd0);
    check({name, "_terminal"}, {done, error, cpu_reset, in_ready},
          {e_done, e_err, !e_done, 1'b0});
  endtask

  typedef struct {
    int          len;
    logic [7:0]  b [12];
    bit          done_e;
    bit          err_e;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t tbl [6];

  task automatic load_vec(input int k);
    frame.delete();
    for (int j = 0; j < tbl[k].len; j++) frame.push_back(tbl[k].b[j]);
    e_done = tbl[k].done_e;
    e_err  = tbl[k].err_e;
    exp_addr.delete();
    exp_data.delete();
    if (tbl[k].nw >= 1) begin exp_addr.push_back(32'h0); exp_data.push_back(tbl[k].w0); end
    if (tbl[k].nw >= 2) begin exp_addr.push_back(32'h4); exp_data.push_back(tbl[k].w1); end
  endtask

  initial begin
    int         n;
    int         r;
    int         base;
    logic [7:0] x;
    logic [7:0] b;

    tbl[0] = '{11, '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h08, 8'h00},
               1'b1, 1'b0, 2, 32'h12345678, 32'hAABBCCDD};
    tbl[1] = '{3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b1, 1'b0, 0, 32'h0, 32'h0};
    tbl[2] = '{2, '{8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0, 1'b1, 0, 32'h0, 32'h0};
    tbl[3] = '{11, '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h09, 8'h00},
               1'b0, 1'b1, 2, 32'h12345678, 32'hAABBCCDD};
    tbl[4] = '{2, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0, 1'b1, 0, 32'h0, 32'h0};
    tbl[5] = '{7, '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h0};

    // Fixed vectors, back-to-back bytes
    for (int k = 0; k < 6; k++) begin
      do_reset();
      load_vec(k);
      run_frame($sformatf("vec%0d", k), tbl[k].len, 0);
    end

    // Frame 1 with random idle gaps of up to 5 cycles
    for (int k = 0; k < 3; k++) begin
      do_reset();
      load_vec(0);
      run_frame($sformatf("gaps%0d", k), 11, 5);
    end

    // Reset in the middle of a load, then a full reload from BASE_ADDR
    do_reset();
    load_vec(0);
    base = got_addr.size();
    send_bytes(8, 0);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("midreset_partial_writes", got_addr.size() - base, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("midreset_vals");
    @(negedge clock);
    check_reset_vals("midreset_vals_held");
    reset = 1'b1;
    load_vec(0);
    run_frame("midreset_reload", 11, 1);

    // Randomized frames against the reference model
    for (int k = 0; k < 25; k++) begin
      do_reset();
      r = $urandom_range(9, 0);
      if (r == 0)      n = $urandom_range(65535, 65);
      else if (r == 1) n = 64;
      else             n = $urandom_range(5, 0);
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      if (n <= 64) begin
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          b = 8'($urandom);
          x = x ^ b;
          frame.push_back(b);
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        frame.push_back(x);
      end
      model();
      run_frame($sformatf("rand%0d_n%0d", k, n), n_acc, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
